// File: rtl/icache_l15_miss_queue.sv
// I$ line-miss queue: buffers core misses, issues one at a time to the L1.5 adapter, returns refills.
// Latency: request visible to L1.5 the cycle after enqueue; refill forwarded to core in the same cycle.
// Backpressure: none toward the core (full FIFO drops + sticky overflow); valid/ready toward L1.5.
module icache_l15_miss_queue #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 512,
  parameter int LINE_BYTES = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_l,
  input  logic                  core_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] core_req_paddr_i,
  input  logic                  flush_i,
  output logic                  l15_req_valid_o,
  input  logic                  l15_req_ready_i,
  output logic [ADDR_WIDTH-1:0] l15_req_paddr_o,
  input  logic                  l15_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] l15_resp_data_i,
  output logic                  core_resp_valid_o,
  output logic [DATA_WIDTH-1:0] core_resp_data_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  spurious_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr, newest_idx;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] inflight_addr;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  fifo_full, fifo_empty;
  logic                  dup, pop, push, drop_full;
  logic                  spurious_set;

  assign aligned_addr = core_req_paddr_i & ~OFF_MASK;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CW'(DEPTH));
  assign newest_idx   = wr_ptr - PW'(1);

  // A miss already queued last, or the one in flight, is merged rather than re-requested.
  // A miss being swallowed after flush is not a match: its refill never reaches the core.
  assign dup = (~fifo_empty & (mem[newest_idx] == aligned_addr)) |
               ((state == WAIT) & (inflight_addr == aligned_addr));

  assign pop       = l15_req_valid_o & l15_req_ready_i;
  assign push      = core_req_valid_i & ~flush_i & ~dup & (~fifo_full | pop);
  assign drop_full = core_req_valid_i & ~flush_i & ~dup & fifo_full & ~pop;

  assign l15_req_paddr_o  = mem[rd_ptr];
  assign core_resp_data_o = l15_resp_data_i;
  assign busy_o           = ~fifo_empty | (state != IDLE);

  // Miss FIFO storage, pointers and occupancy; flush empties it on the next cycle.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= aligned_addr;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Capture the issued address so later requests to the same line merge with it.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l)  inflight_addr <= '0;
    else if (pop)  inflight_addr <= l15_req_paddr_o;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      overflow_o <= 1'b0;
      spurious_o <= 1'b0;
    end else begin
      if (drop_full)    overflow_o <= 1'b1;
      if (spurious_set) spurious_o <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state: a flush while waiting turns the in-flight miss into one to be swallowed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = flush_i ? WAIT_DROP : WAIT;
      WAIT: begin
        if (l15_resp_valid_i) state_next = IDLE;
        else if (flush_i)     state_next = WAIT_DROP;
      end
      WAIT_DROP: if (l15_resp_valid_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM outputs: issue only from IDLE, forward refills only for a live miss.
  always_comb begin
    l15_req_valid_o   = 1'b0;
    core_resp_valid_o = 1'b0;
    spurious_set      = 1'b0;
    case (state)
      IDLE: begin
        l15_req_valid_o = ~fifo_empty;
        spurious_set    = l15_resp_valid_i;
      end
      WAIT:    core_resp_valid_o = l15_resp_valid_i;
      default: ;
    endcase
  end

endmodule
